// File: rtl/rf_pkg.sv
// Shared types and default sizes for the multi-port register file.
package rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } rf_state_t;

  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_NUM_REGS = 32;
  localparam int unsigned RF_ZERO     = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on reserve, cleared on write.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int unsigned NUM_REGS = RF_NUM_REGS,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Set is applied after clear so a new producer supersedes the completing one.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (clr_en) busy_d[clr_addr] = 1'b0;
      if (set_en) busy_d[set_addr] = 1'b1;
    end
    busy_d[RF_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, single-write register file with zero register, sequenced clear and scoreboard.
// Optional build macro RF_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp
  import rf_pkg::*;
#(
  parameter  int unsigned DATA_W   = RF_DATA_W,
  parameter  int unsigned NUM_REGS = RF_NUM_REGS,
  parameter  int unsigned NUM_RD   = 2,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_req,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [NUM_REGS-1:0]      busy
);

  rf_state_t           state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   rf_q [NUM_REGS];

  logic                in_clear;
  logic                accept;
  logic                wr_fire;
  logic                rsv_fire;
  logic                flush;
  logic                arr_we;
  logic [ADDR_W-1:0]   arr_addr;
  logic [DATA_W-1:0]   arr_data;
  logic [ADDR_W-1:0]   ra;

  // Clear sequencer: register 0 is never stored, so the walk covers 1..NUM_REGS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(NUM_REGS - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = ADDR_W'(1);
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = ADDR_W'(1);
      end
    endcase
  end

  assign in_clear = (state_q == CLEAR);
  assign ready    = (state_q == IDLE);
  assign accept   = ready && !clr_req;
  assign wr_fire  = accept && wr_en  && (wr_addr  != ADDR_W'(RF_ZERO));
  assign rsv_fire = accept && rsv_en && (rsv_addr != ADDR_W'(RF_ZERO));
  assign flush    = in_clear || clr_req;

  // Single array write port shared by the clear walk and the functional write.
  always_comb begin
    arr_we   = wr_fire;
    arr_addr = wr_addr;
    arr_data = wr_data;
    if (in_clear) begin
      arr_we   = 1'b1;
      arr_addr = cnt_q;
      arr_data = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) rf_q[arr_addr] <= arr_data;
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .set_en   (rsv_fire),
    .set_addr (rsv_addr),
    .clr_en   (wr_fire),
    .clr_addr (wr_addr),
    .busy     (busy)
  );

  // Read ports; zero register and clear-in-progress read as zero.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      if (!in_clear && (ra != ADDR_W'(RF_ZERO))) begin
        rd_data[k*DATA_W +: DATA_W] = rf_q[ra];
        rd_busy[k]                  = busy[ra];
`ifdef RF_BYPASS_EN
        if (wr_fire && (wr_addr == ra)) begin
          rd_data[k*DATA_W +: DATA_W] = wr_data;
          rd_busy[k]                  = rsv_fire && (rsv_addr == ra);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (32 x 32, two read ports).
module tb_regfile_mp;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned NUM_RD   = 2;
  localparam int unsigned ADDR_W   = 5;

  logic                     clk;
  logic                     rst_n;
  logic                     clr_req;
  logic                     ready;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [NUM_REGS-1:0]      busy;

  int errors = 0;
  int checks = 0;
  int edges;

  regfile_mp #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .ready    (ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count rising edges until ready is seen high; -1 if the bound expires.
  task automatic count_to_ready(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = {ADDR_W'(2*i+1), ADDR_W'(2*i)};
      #1;
      chk(tag, {32'h0, rd_data[31:0] | rd_data[63:32]}, 64'h0);
    end
  endtask

  task automatic idle_inputs();
    clr_req  = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    idle_inputs();
    #1;
    chk("reset_ready", 64'(ready), 64'h0);
    chk("reset_busy",  64'(busy),  64'h0);
    repeat (2) @(negedge clk);

    // Power-on clear with a write and a reservation held throughout.
    wr_en    = 1'b1;
    wr_addr  = 5'd2;
    wr_data  = 32'h5555_5555;
    rsv_en   = 1'b1;
    rsv_addr = 5'd4;
    rd_addr  = {5'd2, 5'd1};
    rst_n    = 1'b1;
    #1;
    chk("clear_rd_forced0", 64'(rd_data), 64'h0);
    count_to_ready(edges);
    idle_inputs();
    chk("por_clear_edges", 64'(edges), 64'd31);
    chk("por_busy_zero", 64'(busy), 64'h0);
    read_all_zero("por_read_zero");

    // Basic write and read on both ports.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    idle_inputs();
    rd_addr = {5'd5, 5'd5};
    #1;
    chk("r5_port0", 64'(rd_data[31:0]),  64'hDEAD_BEEF);
    chk("r5_port1", 64'(rd_data[63:32]), 64'hDEAD_BEEF);

    // Write to the zero register is ignored.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    @(negedge clk);
    idle_inputs();
    rd_addr = {5'd0, 5'd0};
    #1;
    chk("r0_read", 64'(rd_data), 64'h0);
    chk("r0_busy", 64'(busy), 64'h0);

    // Reserve r7, then complete it.
    rsv_en = 1'b1; rsv_addr = 5'd7;
    @(negedge clk);
    idle_inputs();
    rd_addr = {5'd0, 5'd7};
    #1;
    chk("rsv7_busy", 64'(busy), 64'h80);
    chk("rsv7_rd_busy", 64'(rd_busy), 64'h1);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_1234;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("wr7_busy", 64'(busy), 64'h0);
    chk("wr7_data", 64'(rd_data[31:0]), 64'h1234);

    // Same-cycle reserve and write to r9: reservation wins.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    @(negedge clk);
    idle_inputs();
    rd_addr = {5'd9, 5'd0};
    #1;
    chk("rsvwr9_busy", 64'(busy), 64'h200);
    chk("rsvwr9_rd_busy", 64'(rd_busy), 64'h2);
    chk("rsvwr9_data", 64'(rd_data[63:32]), 64'h99);

    // Same-cycle write and read of r3 and of busy r9.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5_A5A5;
    rd_addr = {5'd5, 5'd3};
    #1;
`ifdef RF_BYPASS_EN
    chk("bypass_r3", 64'(rd_data[31:0]), 64'hA5A5_A5A5);
`else
    chk("bypass_r3", 64'(rd_data[31:0]), 64'h0);
`endif
    chk("bypass_other_port", 64'(rd_data[63:32]), 64'hDEAD_BEEF);
    @(negedge clk);
    wr_addr = 5'd9; wr_data = 32'h1999;
    rd_addr = {5'd3, 5'd9};
    #1;
`ifdef RF_BYPASS_EN
    chk("bypass_r9_busy", 64'(rd_busy), 64'h0);
    chk("bypass_r9_data", 64'(rd_data[31:0]), 64'h1999);
`else
    chk("bypass_r9_busy", 64'(rd_busy), 64'h1);
    chk("bypass_r9_data", 64'(rd_data[31:0]), 64'h99);
`endif
    chk("r3_after_write", 64'(rd_data[63:32]), 64'hA5A5_A5A5);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("wr9_busy_clear", 64'(busy), 64'h0);

    // Fill r1..r31 with their index, reserve r10, then request a clear.
    for (int i = 1; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(i);
      @(negedge clk);
    end
    idle_inputs();
    rsv_en = 1'b1; rsv_addr = 5'd10;
    @(negedge clk);
    idle_inputs();
    rd_addr = {5'd31, 5'd17};
    #1;
    chk("fill_r17", 64'(rd_data[31:0]), 64'd17);
    chk("fill_r31", 64'(rd_data[63:32]), 64'd31);
    chk("fill_busy10", 64'(busy), 64'h400);
    clr_req = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h77;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("clr_ready_low", 64'(ready), 64'h0);
    chk("clr_busy_flush", 64'(busy), 64'h0);
    count_to_ready(edges);
    chk("clr_edges", 64'(edges), 64'd31);
    chk("clr_busy_after", 64'(busy), 64'h0);
    read_all_zero("clr_read_zero");

    // Reset in the middle of a clear restarts the full walk.
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midclr_ready_low", 64'(ready), 64'h0);
    rst_n = 1'b0;
    #1;
    chk("midclr_reset_ready", 64'(ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    count_to_ready(edges);
    chk("midclr_edges", 64'(edges), 64'd31);
    read_all_zero("midclr_read_zero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
